fb_conditioner: RTL and testbench



---
 rtl/fb_conditioner_pkg.sv | 16 +
 rtl/fb_conditioner_if.sv | 24 ++
 rtl/fb_sync_filter.sv | 77 +++++++
 rtl/fb_conditioner.sv | 92 +++++++++
 tb/tb_fb_conditioner.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fb_conditioner_pkg.sv
// Shared constants and helpers for the PLL feedback conditioner.
// NOSIG_CYC is derived from the clock and minimum input frequency so the PLL core's lockout agrees.
package fb_conditioner_pkg;

   localparam int CLK_HZ          = 50_000_000;
   localparam int FREQ_MIN_HZ     = 50_000;
   localparam int NOSIG_CYC_DEF   = CLK_HZ / FREQ_MIN_HZ * 2;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int GLITCH_CYC_DEF  = 4;
   localparam int PERIOD_W_DEF    = 20;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fb_conditioner_if.sv
// Conditioned-feedback bus: raw pin in, clean level/strobes/measurements out.
interface fb_conditioner_if
   import fb_conditioner_pkg::*;
#(
   parameter int PERIOD_W = PERIOD_W_DEF
);
   logic                fb_u;
   logic                fb;
   logic                fb_rise;
   logic [PERIOD_W-1:0] period;
   logic                period_valid;
   logic                nosig;
   logic [7:0]          glitch_cnt;

   modport slave (
      input  fb_u,
      output fb, fb_rise, period, period_valid, nosig, glitch_cnt
   );

   modport master (
      output fb_u,
      input  fb, fb_rise, period, period_valid, nosig, glitch_cnt
   );
endinterface

// File: rtl/fb_sync_filter.sv
// Synchroniser and glitch filter for the raw feedback pin.
// fb only follows the synced input after GLITCH_CYC consecutive disagreeing cycles.
module fb_sync_filter
   import fb_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int GLITCH_CYC  = GLITCH_CYC_DEF
)(
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       fb_u,
   output logic       fb,
   output logic       fb_rise,
   output logic       fb_edge,
   output logic [7:0] glitch_cnt
);

   localparam int STAB_W = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(GLITCH_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [STAB_W-1:0]      stab_q, stab_d;
   logic                   fb_q, fb_d;
   logic                   rise_q, rise_d;
   logic                   edge_q, edge_d;
   logic [7:0]             glitch_q, glitch_d;
   logic                   fb_s;

   assign fb_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], fb_u};
      stab_d   = stab_q;
      fb_d     = fb_q;
      rise_d   = 1'b0;
      edge_d   = 1'b0;
      glitch_d = glitch_q;
      if (fb_s != fb_q) begin
         if (stab_q == STAB_LAST) begin
            fb_d   = fb_s;
            stab_d = '0;
            edge_d = 1'b1;
            rise_d = fb_s;
         end else begin
            stab_d = stab_q + STAB_W'(1);
         end
      end else if (stab_q != '0) begin
         // Input fell back before the run completed: that pulse was a glitch
         stab_d   = '0;
         glitch_d = sat_inc8(glitch_q);
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stab_q   <= '0;
         fb_q     <= 1'b0;
         rise_q   <= 1'b0;
         edge_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         sync_q   <= sync_d;
         stab_q   <= stab_d;
         fb_q     <= fb_d;
         rise_q   <= rise_d;
         edge_q   <= edge_d;
         glitch_q <= glitch_d;
      end
   end

   assign fb         = fb_q;
   assign fb_rise    = rise_q;
   assign fb_edge    = edge_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: rtl/fb_conditioner.sv
// Feedback conditioner: clean fb level, rise-to-rise period measurement and loss-of-signal flag.
module fb_conditioner
   import fb_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int GLITCH_CYC  = GLITCH_CYC_DEF,
   parameter int PERIOD_W    = PERIOD_W_DEF,
   parameter int NOSIG_CYC   = NOSIG_CYC_DEF
)(
   input  logic             clk_50,
   input  logic             rst_n,
   fb_conditioner_if.slave  bus
);

   localparam int LS_W = $clog2(NOSIG_CYC + 1);
   localparam logic [LS_W-1:0]     LS_MAX  = LS_W'(NOSIG_CYC);
   localparam logic [PERIOD_W-1:0] PER_MAX = '1;

   logic       fb, fb_rise, fb_edge;
   logic [7:0] glitch_cnt;

   logic [PERIOD_W-1:0] per_q, per_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                pvalid_q, pvalid_d;
   logic                armed_q, armed_d;
   logic [LS_W-1:0]     ls_q, ls_d;
   logic                nosig_q, nosig_d;

   fb_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .GLITCH_CYC  (GLITCH_CYC)
   ) u_filter (
      .clk_50     (clk_50),
      .rst_n      (rst_n),
      .fb_u       (bus.fb_u),
      .fb         (fb),
      .fb_rise    (fb_rise),
      .fb_edge    (fb_edge),
      .glitch_cnt (glitch_cnt)
   );

   always_comb begin
      per_d    = (per_q == PER_MAX) ? per_q : per_q + PERIOD_W'(1);
      period_d = period_q;
      pvalid_d = 1'b0;
      armed_d  = armed_q;
      if (fb_rise) begin
         per_d   = PERIOD_W'(1);
         armed_d = 1'b1;
         // A saturated counter means the interval overflowed, so it is not reported
         if (armed_q && (per_q != PER_MAX)) begin
            period_d = per_q;
            pvalid_d = 1'b1;
         end
      end else if (nosig_q) begin
         armed_d = 1'b0;
      end

      ls_d    = (ls_q == LS_MAX) ? ls_q : ls_q + LS_W'(1);
      nosig_d = (ls_q == LS_MAX);
      if (fb_edge) begin
         ls_d    = '0;
         nosig_d = 1'b0;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         per_q    <= '0;
         period_q <= '0;
         pvalid_q <= 1'b0;
         armed_q  <= 1'b0;
         ls_q     <= '0;
         nosig_q  <= 1'b0;
      end else begin
         per_q    <= per_d;
         period_q <= period_d;
         pvalid_q <= pvalid_d;
         armed_q  <= armed_d;
         ls_q     <= ls_d;
         nosig_q  <= nosig_d;
      end
   end

   assign bus.fb           = fb;
   assign bus.fb_rise      = fb_rise;
   assign bus.period       = period_q;
   assign bus.period_valid = pvalid_q;
   assign bus.nosig        = nosig_q;
   assign bus.glitch_cnt   = glitch_cnt;

endmodule

// File: tb/tb_fb_conditioner.sv
// Self-checking bench for fb_conditioner: directed scenarios plus randomized pin activity
// compared each cycle against a timestamp-based reference model.
module tb_fb_conditioner;
   import fb_conditioner_pkg::*;

   localparam int SS   = 2;
   localparam int GC   = 4;
   localparam int PW   = 20;
   localparam int NC   = NOSIG_CYC_DEF;
   localparam int PMAX = (1 << PW) - 1;

   logic clk_50 = 1'b0;
   logic rst_n  = 1'b0;

   fb_conditioner_if #(.PERIOD_W(PW)) bus();

   fb_conditioner #(
      .SYNC_STAGES (SS),
      .GLITCH_CYC  (GC),
      .PERIOD_W    (PW),
      .NOSIG_CYC   (NC)
   ) dut (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_50 = ~clk_50;

   int vectors     = 0;
   int miscompares = 0;
   int pv_seen     = 0;
   int fb_hi_cyc   = 0;

   // Reference model state: cycle index since reset and event timestamps
   int   m_c, m_last_edge, m_last_rise, m_run, m_glitch, m_period;
   bit   m_has_rise;
   logic m_p1, m_p2, m_fb, m_rise, m_edge, m_armed, m_nosig, m_pvalid;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_c = 0; m_last_edge = -1; m_last_rise = 0; m_has_rise = 0;
      m_run = 0; m_glitch = 0; m_period = 0;
      m_p1 = 0; m_p2 = 0; m_fb = 0; m_rise = 0; m_edge = 0;
      m_armed = 0; m_nosig = 0; m_pvalid = 0;
   endtask

   // Advance the model by one clock edge; pin is the fb_u value sampled at this edge
   task automatic modelStep(input logic pin);
      int   age;
      logic fbs;
      m_c++;
      age = m_has_rise ? (m_c - 1 - m_last_rise) : (m_c - 1);
      if (age > PMAX) age = PMAX;
      m_pvalid = m_rise && m_armed && (age < PMAX);
      if (m_pvalid) m_period = age;
      if (m_rise) begin
         m_armed = 1; m_last_rise = m_c - 1; m_has_rise = 1;
      end else if (m_nosig) begin
         m_armed = 0;
      end
      if (m_edge) m_last_edge = m_c - 1;
      m_nosig = ((m_c - 2 - m_last_edge) >= NC);

      fbs = m_p2; m_p2 = m_p1; m_p1 = pin;
      m_rise = 0; m_edge = 0;
      if (fbs != m_fb) begin
         m_run++;
         if (m_run == GC) begin
            m_fb = fbs; m_run = 0; m_edge = 1; m_rise = fbs;
         end
      end else if (m_run > 0) begin
         m_run = 0;
         if (m_glitch < 255) m_glitch++;
      end
   endtask

   task automatic applyStimulus(input logic v);
      bus.fb_u = v;
      @(posedge clk_50);
      modelStep(v);
      #1;
      if (bus.period_valid === 1'b1) pv_seen++;
      if (bus.fb === 1'b1) fb_hi_cyc++;
      checkOutput($sformatf("c%0d_fb", m_c),           32'(bus.fb),           32'(m_fb));
      checkOutput($sformatf("c%0d_fb_rise", m_c),      32'(bus.fb_rise),      32'(m_rise));
      checkOutput($sformatf("c%0d_period", m_c),       32'(bus.period),       32'(m_period));
      checkOutput($sformatf("c%0d_period_valid", m_c), 32'(bus.period_valid), 32'(m_pvalid));
      checkOutput($sformatf("c%0d_nosig", m_c),        32'(bus.nosig),        32'(m_nosig));
      checkOutput($sformatf("c%0d_glitch_cnt", m_c),   32'(bus.glitch_cnt),   32'(m_glitch));
   endtask

   task automatic runHold(input logic v, input int n);
      for (int i = 0; i < n; i++) applyStimulus(v);
   endtask

   task automatic runWave(input int hi, input int lo, input int count);
      for (int i = 0; i < count; i++) begin
         runHold(1'b1, hi);
         runHold(1'b0, lo);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_fb"},           32'(bus.fb),           32'd0);
      checkOutput({tag, "_fb_rise"},      32'(bus.fb_rise),      32'd0);
      checkOutput({tag, "_period"},       32'(bus.period),       32'd0);
      checkOutput({tag, "_period_valid"}, 32'(bus.period_valid), 32'd0);
      checkOutput({tag, "_nosig"},        32'(bus.nosig),        32'd0);
      checkOutput({tag, "_glitch_cnt"},   32'(bus.glitch_cnt),   32'd0);
   endtask

   initial begin
      int   lag;
      bit   seen;
      logic lvl;
      int   n;

      bus.fb_u = 1'b0;
      rst_n    = 1'b0;
      modelReset();
      repeat (3) @(posedge clk_50);
      #1;
      checkAllZero("reset");
      @(negedge clk_50);
      rst_n = 1'b1;

      $display("[TB] phase 1: idle low, loss of signal");
      runHold(1'b0, NC);
      checkOutput("p1_nosig_before", 32'(bus.nosig), 32'd0);
      applyStimulus(1'b0);
      checkOutput("p1_nosig_at", 32'(bus.nosig), 32'd1);
      runHold(1'b0, 3000 - NC - 1);

      $display("[TB] phase 2: clean 200-cycle square wave");
      pv_seen = 0;
      lag     = 0;
      seen    = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1);
         if (!seen && bus.fb === 1'b1) begin
            lag  = i + 1;
            seen = 1;
         end
      end
      checkOutput("p2_lag", 32'(lag), 32'(SS + GC));
      runHold(1'b0, 100);
      runWave(100, 100, 5);
      checkOutput("p2_pv_count", 32'(pv_seen), 32'd5);
      checkOutput("p2_period",   32'(bus.period), 32'd200);

      $display("[TB] phase 3: short pulses");
      runHold(1'b0, 20);
      runHold(1'b1, 2);
      runHold(1'b0, 20);
      checkOutput("p3_glitch_after_2", 32'(bus.glitch_cnt), 32'd1);
      runHold(1'b1, 3);
      runHold(1'b0, 20);
      checkOutput("p3_glitch_after_3", 32'(bus.glitch_cnt), 32'd2);
      fb_hi_cyc = 0;
      runHold(1'b1, 4);
      runHold(1'b0, 20);
      checkOutput("p3_fb_hi_cycles", 32'(fb_hi_cyc), 32'd4);
      checkOutput("p3_glitch_after_4", 32'(bus.glitch_cnt), 32'd2);

      $display("[TB] phase 4: glitch counter saturation");
      for (int i = 0; i < 300; i++) begin
         runHold(1'b1, 1);
         runHold(1'b0, 7);
      end
      checkOutput("p4_glitch_sat", 32'(bus.glitch_cnt), 32'd255);

      $display("[TB] phase 5: signal loss and recovery");
      runWave(100, 100, 4);
      runHold(1'b0, 2500);
      checkOutput("p5_nosig", 32'(bus.nosig), 32'd1);
      pv_seen = 0;
      runWave(100, 100, 3);
      checkOutput("p5_pv_count", 32'(pv_seen), 32'd2);
      checkOutput("p5_period",   32'(bus.period), 32'd200);
      checkOutput("p5_nosig_off", 32'(bus.nosig), 32'd0);

      $display("[TB] phase 6: reset mid-measurement");
      runHold(1'b0, 120);
      runHold(1'b1, SS + GC + 50);
      rst_n = 1'b0;
      #1;
      checkAllZero("p6_async");
      repeat (5) @(posedge clk_50);
      @(negedge clk_50);
      rst_n = 1'b1;
      modelReset();
      pv_seen = 0;
      runHold(1'b1, 44);
      runHold(1'b0, 100);
      checkOutput("p6_no_pv", 32'(pv_seen), 32'd0);
      runWave(100, 100, 2);

      $display("[TB] phase 7: randomized pin activity");
      lvl = 1'b0;
      for (int i = 0; i < 400; i++) begin
         lvl = ~lvl;
         n   = $urandom_range(1, 12);
         if ($urandom_range(0, 9) == 0) n = $urandom_range(150, 400);
         runHold(lvl, n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
